// File: rtl/cv32e40s_obi_instr_master_pkg.sv
// Shared types for the OBI instruction-fetch master.
// Defines the adapter FSM states and the A/R channel payload structs.
package cv32e40s_obi_instr_master_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_PROT_W = 3;
    localparam int OBI_DATA_W = 32;

    typedef enum logic [0:0] {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } obi_if_state_e;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_PROT_W-1:0] prot;
    } obi_inst_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_inst_resp_t;

endpackage

// File: rtl/cv32e40s_obi_instr_master_if.sv
// OBI instruction bus bundle: A channel (req/gnt/payload) and R channel (rvalid/payload).
// The master modport is driven by the fetch adapter, the slave modport by the bus.
interface if_c_obi
    import cv32e40s_obi_instr_master_pkg::*;
();
    logic           s_req;
    logic           s_gnt;
    logic           s_rvalid;
    obi_inst_req_t  req_payload;
    obi_inst_resp_t resp_payload;

    modport master (
        output s_req,
        output req_payload,
        input  s_gnt,
        input  s_rvalid,
        input  resp_payload
    );

    modport slave (
        input  s_req,
        input  req_payload,
        output s_gnt,
        output s_rvalid,
        output resp_payload
    );
endinterface

// File: rtl/cv32e40s_obi_instr_master_outstanding_cnt.sv
// Saturating outstanding-transaction counter with a sticky underflow flag.
// Latency: count updates one cycle after inc/dec; no backpressure (pure bookkeeping).
// Backpressure: none; the owner gates inc so the count never passes MAX_OUTSTANDING.
module cv32e40s_obi_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_underflow;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_underflow;

    // Simultaneous inc and dec cancel; a dec at zero is a bus protocol violation.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_underflow = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_cnt != CNT_W'(MAX_OUTSTANDING)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (!i_inc && i_dec) begin
            if (r_cnt == '0) begin
                w_underflow = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_underflow <= r_underflow | w_underflow;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/cv32e40s_obi_instr_master.sv
// OBI instruction-fetch master: turns prefetcher requests into OBI A-channel cycles and forwards R responses.
// Latency: zero (A payload and responses pass combinationally); a stalled grant parks the payload in registers.
// Backpressure: trans_ready_o drops while a request waits for gnt or the outstanding limit is reached.
module cv32e40s_obi_instr_master
    import cv32e40s_obi_instr_master_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trans_valid_i,
    output logic                  trans_ready_o,
    input  logic [OBI_ADDR_W-1:0] trans_addr_i,
    input  logic [OBI_PROT_W-1:0] trans_prot_i,
    if_c_obi.master               m_c_obi,
    output logic                  resp_valid_o,
    output logic [OBI_DATA_W-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  protocol_err_o
);

    obi_if_state_e r_state;
    obi_if_state_e w_state_nxt;
    obi_inst_req_t r_hold;
    obi_inst_req_t w_payload;
    logic          r_started;
    logic          w_req;
    logic          w_ready;
    logic          w_capture;
    logic [CNT_W-1:0] w_cnt;

    // Ready ignores gnt so that req never combinationally depends on gnt.
    assign w_ready = r_started && (r_state == TRANSPARENT) &&
                     ((w_cnt < CNT_W'(MAX_OUTSTANDING)) || m_c_obi.s_rvalid);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_capture   = 1'b0;
        w_payload   = '{addr: trans_addr_i, prot: trans_prot_i};
        case (r_state)
            TRANSPARENT: begin
                w_req = trans_valid_i && w_ready;
                if (w_req && !m_c_obi.s_gnt) begin
                    w_state_nxt = REGISTERED;
                    w_capture   = 1'b1;
                end
            end
            REGISTERED: begin
                w_req     = 1'b1;
                w_payload = r_hold;
                if (m_c_obi.s_gnt) begin
                    w_state_nxt = TRANSPARENT;
                end
            end
            default: begin
                w_state_nxt = TRANSPARENT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TRANSPARENT;
            r_started <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_capture) begin
                r_hold <= '{addr: trans_addr_i, prot: trans_prot_i};
            end
        end
    end

    cv32e40s_obi_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_req && m_c_obi.s_gnt),
        .i_dec       (m_c_obi.s_rvalid),
        .o_cnt       (w_cnt),
        .o_underflow (protocol_err_o)
    );

    assign m_c_obi.s_req       = w_req;
    assign m_c_obi.req_payload = w_payload;
    assign trans_ready_o       = w_ready;
    assign outstanding_o       = w_cnt;

    assign resp_valid_o = m_c_obi.s_rvalid;
    assign resp_rdata_o = m_c_obi.resp_payload.rdata;
    assign resp_err_o   = m_c_obi.resp_payload.err & m_c_obi.s_rvalid;

endmodule

// File: tb/tb_cv32e40s_obi_instr_master.sv
// Bench for the OBI instruction master: directed vector table, an async-reset sequence,
// then randomized traffic against a transaction-level reference model.
module tb_cv32e40s_obi_instr_master;
    import cv32e40s_obi_instr_master_pkg::*;

    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          trans_valid_i;
    logic          trans_ready_o;
    logic [31:0]   trans_addr_i;
    logic [2:0]    trans_prot_i;
    logic          resp_valid_o;
    logic [31:0]   resp_rdata_o;
    logic          resp_err_o;
    logic [CW-1:0] outstanding_o;
    logic          protocol_err_o;

    if_c_obi bus ();

    cv32e40s_obi_instr_master #(.MAX_OUTSTANDING(MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trans_valid_i  (trans_valid_i),
        .trans_ready_o  (trans_ready_o),
        .trans_addr_i   (trans_addr_i),
        .trans_prot_i   (trans_prot_i),
        .m_c_obi        (bus),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] p,
                         input logic g, input logic rv, input logic [31:0] rd, input logic e);
        trans_valid_i                = v;
        trans_addr_i                 = a;
        trans_prot_i                 = p;
        bus.s_gnt                    = g;
        bus.s_rvalid                 = rv;
        bus.resp_payload.rdata       = rd;
        bus.resp_payload.err         = e;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [2:0]  p;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        e;
        logic        x_rdy;
        logic        x_req;
        logic [31:0] x_addr;
        logic [2:0]  x_prot;
        logic        x_err;
        int          x_cnt;
        logic        x_perr;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] a, logic [2:0] p, logic g, logic rv,
                                logic [31:0] rd, logic e, logic x_rdy, logic x_req,
                                logic [31:0] x_addr, logic [2:0] x_prot, logic x_err,
                                int x_cnt, logic x_perr);
        vec_t r;
        r.v = v; r.a = a; r.p = p; r.g = g; r.rv = rv; r.rd = rd; r.e = e;
        r.x_rdy = x_rdy; r.x_req = x_req; r.x_addr = x_addr; r.x_prot = x_prot;
        r.x_err = x_err; r.x_cnt = x_cnt; r.x_perr = x_perr;
        return r;
    endfunction

    vec_t tbl [13];

    // Transaction-level model: a pending (ungranted) fetch, an outstanding count, a sticky error.
    bit          m_pend;
    logic [31:0] m_addr;
    logic [2:0]  m_prot;
    int          m_cnt;
    bit          m_perr;

    initial begin
        logic        v, g, rv, e;
        logic [31:0] a, rd;
        logic [2:0]  p;
        logic        x_rdy, x_req, granted;

        //            v  addr   p  g rv rdata         e   rdy req addr   prot err cnt perr
        tbl[0]  = mk(1, 32'h100, 2, 1, 0, 32'h0,        0,  1, 1, 32'h100, 2, 0, 0, 0);
        tbl[1]  = mk(0, 32'h0,   0, 0, 0, 32'h0,        0,  1, 0, 32'h0,   0, 0, 1, 0);
        tbl[2]  = mk(1, 32'h200, 2, 0, 0, 32'h0,        0,  1, 1, 32'h200, 2, 0, 1, 0);
        tbl[3]  = mk(1, 32'h300, 7, 0, 0, 32'h0,        0,  0, 1, 32'h200, 2, 0, 1, 0);
        tbl[4]  = mk(0, 32'h300, 7, 0, 0, 32'h0,        0,  0, 1, 32'h200, 2, 0, 1, 0);
        tbl[5]  = mk(0, 32'h300, 7, 1, 0, 32'h0,        0,  0, 1, 32'h200, 2, 0, 1, 0);
        tbl[6]  = mk(1, 32'h300, 7, 0, 0, 32'h0,        0,  0, 0, 32'h300, 7, 0, 2, 0);
        tbl[7]  = mk(1, 32'h400, 5, 1, 1, 32'hDEADBEEF, 1,  1, 1, 32'h400, 5, 1, 2, 0);
        tbl[8]  = mk(0, 32'h0,   0, 0, 1, 32'h12345678, 0,  1, 0, 32'h0,   0, 0, 2, 0);
        tbl[9]  = mk(0, 32'h0,   0, 0, 1, 32'h0,        1,  1, 0, 32'h0,   0, 1, 1, 0);
        tbl[10] = mk(0, 32'h0,   0, 0, 0, 32'h0,        1,  1, 0, 32'h0,   0, 0, 0, 0);
        tbl[11] = mk(0, 32'h0,   0, 0, 1, 32'hCAFE,     0,  1, 0, 32'h0,   0, 0, 0, 0);
        tbl[12] = mk(0, 32'h0,   0, 0, 0, 32'h0,        0,  1, 0, 32'h0,   0, 0, 0, 1);

        // Reset state, with the prefetcher already asking.
        drive(1, 32'h80, 1, 1, 0, 0, 0);
        #12;
        chk("rst_req", bus.s_req, 0);
        chk("rst_ready", trans_ready_o, 0);
        chk("rst_cnt", outstanding_o, 0);
        chk("rst_perr", protocol_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pre_edge_ready", trans_ready_o, 0);
        chk("pre_edge_req", bus.s_req, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].p, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].e);
            #3;
            chk($sformatf("v%0d_ready", i), trans_ready_o, tbl[i].x_rdy);
            chk($sformatf("v%0d_req", i), bus.s_req, tbl[i].x_req);
            chk($sformatf("v%0d_addr", i), bus.req_payload.addr, tbl[i].x_addr);
            chk($sformatf("v%0d_prot", i), bus.req_payload.prot, tbl[i].x_prot);
            chk($sformatf("v%0d_rvalid", i), resp_valid_o, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("v%0d_rdata", i), resp_rdata_o, tbl[i].rd);
            chk($sformatf("v%0d_rerr", i), resp_err_o, tbl[i].x_err);
            chk($sformatf("v%0d_cnt", i), outstanding_o, tbl[i].x_cnt);
            chk($sformatf("v%0d_perr", i), protocol_err_o, tbl[i].x_perr);
            @(posedge clk);
            #1;
        end

        // Async reset while a request sits in the registered state with one outstanding.
        drive(1, 32'h500, 3, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h600, 4, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 32'h700, 0, 0, 0, 0, 0);
        #1;
        chk("ar_pre_req", bus.s_req, 1);
        chk("ar_pre_addr", bus.req_payload.addr, 32'h600);
        chk("ar_pre_cnt", outstanding_o, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_req", bus.s_req, 0);
        chk("ar_cnt", outstanding_o, 0);
        chk("ar_ready", trans_ready_o, 0);
        chk("ar_perr", protocol_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_after_req", bus.s_req, 0);
        chk("ar_after_ready", trans_ready_o, 1);

        // Randomized traffic against the model.
        m_pend = 0; m_addr = 0; m_prot = 0; m_cnt = 0; m_perr = 0;
        for (int n = 0; n < 3000; n++) begin
            v  = 1'($urandom % 2);
            a  = $urandom & 32'hFFFF_FFFC;
            p  = 3'($urandom % 8);
            g  = ($urandom % 3) != 0;
            rv = (m_cnt > 0) ? 1'($urandom % 2) : (($urandom % 16) == 0);
            rd = $urandom;
            e  = 1'($urandom % 2);
            drive(v, a, p, g, rv, rd, e);
            #3;
            x_rdy = !m_pend && ((m_cnt < MAX) || rv);
            x_req = m_pend ? 1'b1 : (v && x_rdy);
            chk("rnd_ready", trans_ready_o, x_rdy);
            chk("rnd_req", bus.s_req, x_req);
            if (x_req) begin
                chk("rnd_addr", bus.req_payload.addr, m_pend ? m_addr : a);
                chk("rnd_prot", bus.req_payload.prot, m_pend ? m_prot : p);
            end
            chk("rnd_cnt", outstanding_o, m_cnt);
            chk("rnd_perr", protocol_err_o, m_perr);
            chk("rnd_rvalid", resp_valid_o, rv);
            chk("rnd_rerr", resp_err_o, e && rv);
            if (rv) chk("rnd_rdata", resp_rdata_o, rd);

            granted = x_req && g;
            if (x_req && !g) begin
                if (!m_pend) begin
                    m_addr = a;
                    m_prot = p;
                end
                m_pend = 1;
            end else if (granted) begin
                m_pend = 0;
            end
            if (rv && m_cnt == 0 && !granted) m_perr = 1;
            else m_cnt = m_cnt + int'(granted) - int'(rv);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
